// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch (IF) and data (DM) ports.
// Define ARB_RR_EN to resolve simultaneous requests round-robin instead of fixed DM priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_gnt_out,
    output logic              if_valid_out,
    output logic [DATA_W-1:0] if_rdata_out,
    input  logic              dm_req_in,
    input  logic              dm_we_in,
    input  logic [ADDR_W-1:0] dm_addr_in,
    input  logic [DATA_W-1:0] dm_wdata_in,
    output logic              dm_gnt_out,
    output logic              dm_valid_out,
    output logic [DATA_W-1:0] dm_rdata_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic              stall_out,
    output logic              dbg_state_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int            CW    = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d;   // 0 = IF, 1 = DM
    logic              we_q, we_d;         // granted access is a store
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              pick_dm;

`ifdef ARB_RR_EN
    // Last winner of a contended grant: 0 = IF, 1 = DM.
    logic last_q, last_d;

    always_comb begin
        pick_dm = dm_req_in & (~if_req_in | ~last_q);
        last_d  = last_q;
        if (state_q == ST_IDLE && if_req_in && dm_req_in) begin
            last_d = pick_dm;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        pick_dm = dm_req_in;
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        we_d          = we_q;
        if_valid_d    = 1'b0;
        dm_valid_d    = 1'b0;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        if_gnt_out    = 1'b0;
        dm_gnt_out    = 1'b0;
        mem_en_out    = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;

        case (state_q)
            ST_IDLE: begin
                if (if_req_in || dm_req_in) begin
                    state_d    = ST_WAIT;
                    cnt_d      = LAT_C;
                    owner_d    = pick_dm;
                    mem_en_out = 1'b1;
                    if (pick_dm) begin
                        dm_gnt_out    = 1'b1;
                        mem_we_out    = dm_we_in;
                        mem_addr_out  = dm_addr_in;
                        mem_wdata_out = dm_wdata_in;
                        we_d          = dm_we_in;
                    end else begin
                        if_gnt_out    = 1'b1;
                        mem_addr_out  = if_addr_in;
                        we_d          = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - ONE_C;
                // Final wait cycle: memory data is valid now, capture it for the owner.
                if (cnt_q == ONE_C) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        dm_valid_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata_in;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_in;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_valid_out  = if_valid_q;
    assign dm_valid_out  = dm_valid_q;
    assign if_rdata_out  = if_rdata_q;
    assign dm_rdata_out  = dm_rdata_q;
    assign stall_out     = (state_q == ST_WAIT) | if_req_in | dm_req_in;
    assign dbg_state_out = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: emulates the memory, models arbitration by cycle arithmetic,
// and checks returned data through per-port expected queues.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk;
    logic              reset_in;
    logic              if_req_in;
    logic [ADDR_W-1:0] if_addr_in;
    logic              if_gnt_out;
    logic              if_valid_out;
    logic [DATA_W-1:0] if_rdata_out;
    logic              dm_req_in;
    logic              dm_we_in;
    logic [ADDR_W-1:0] dm_addr_in;
    logic [DATA_W-1:0] dm_wdata_in;
    logic              dm_gnt_out;
    logic              dm_valid_out;
    logic [DATA_W-1:0] dm_rdata_out;
    logic              mem_en_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic [DATA_W-1:0] mem_rdata_in;
    logic              stall_out;
    logic              dbg_state;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .if_req_in    (if_req_in),
        .if_addr_in   (if_addr_in),
        .if_gnt_out   (if_gnt_out),
        .if_valid_out (if_valid_out),
        .if_rdata_out (if_rdata_out),
        .dm_req_in    (dm_req_in),
        .dm_we_in     (dm_we_in),
        .dm_addr_in   (dm_addr_in),
        .dm_wdata_in  (dm_wdata_in),
        .dm_gnt_out   (dm_gnt_out),
        .dm_valid_out (dm_valid_out),
        .dm_rdata_out (dm_rdata_out),
        .mem_en_out   (mem_en_out),
        .mem_we_out   (mem_we_out),
        .mem_addr_out (mem_addr_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in (mem_rdata_in),
        .stall_out    (stall_out),
        .dbg_state_out(dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] if_exp_q[$];
    logic [DATA_W-1:0] dm_exp_q[$];
    logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] mem_arr[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] dm_last_load = '0;

    // access model: one access in flight, identified by its grant cycle
    bit pend = 1'b0;
    bit pend_dm = 1'b0;
    int pend_cyc = 0;
    bit rr_last_dm = 1'b0;

    // memory emulator pending read
    bit                resp_due = 1'b0;
    int                resp_cyc = 0;
    logic [DATA_W-1:0] resp_data = '0;

    function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
        if (a == 32'h40) return 32'h8C02_0004;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory emulator drive ----------------
    initial begin
        mem_rdata_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_due && cyc == resp_cyc) mem_rdata_in = resp_data;
            else mem_rdata_in = $urandom;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit exp_if_v, exp_dm_v, idle, any, g_if, g_dm;
        logic [DATA_W-1:0] e;
        if (!reset_in) begin
            chk1("rst_if_gnt", if_gnt_out, 1'b0);
            chk1("rst_dm_gnt", dm_gnt_out, 1'b0);
            chk1("rst_if_valid", if_valid_out, 1'b0);
            chk1("rst_dm_valid", dm_valid_out, 1'b0);
            chk32("rst_if_rdata", if_rdata_out, 32'h0);
            chk32("rst_dm_rdata", dm_rdata_out, 32'h0);
            chk1("rst_mem_en", mem_en_out, 1'b0);
            chk1("rst_mem_we", mem_we_out, 1'b0);
            chk32("rst_mem_addr", mem_addr_out, 32'h0);
            chk32("rst_mem_wdata", mem_wdata_out, 32'h0);
            chk1("rst_stall", stall_out, if_req_in | dm_req_in);
            pend       = 1'b0;
            resp_due   = 1'b0;
            rr_last_dm = 1'b0;
        end else begin
            exp_if_v = pend && !pend_dm && (cyc == pend_cyc + MEM_LAT + 1);
            exp_dm_v = pend && pend_dm && (cyc == pend_cyc + MEM_LAT + 1);
            chk1("if_valid", if_valid_out, exp_if_v);
            chk1("dm_valid", dm_valid_out, exp_dm_v);
            if (if_valid_out === 1'b1) begin
                if (if_exp_q.size() == 0) chk1("if_exp_q_nonempty", 1'b0, 1'b1);
                else begin
                    e = if_exp_q.pop_front();
                    chk32("if_rdata", if_rdata_out, e);
                end
            end
            if (dm_valid_out === 1'b1) begin
                if (dm_exp_q.size() == 0) chk1("dm_exp_q_nonempty", 1'b0, 1'b1);
                else begin
                    e = dm_exp_q.pop_front();
                    chk32("dm_rdata", dm_rdata_out, e);
                end
            end

            idle = !pend || (cyc > pend_cyc + MEM_LAT);
            any  = if_req_in | dm_req_in;
            chk1("stall", stall_out, !idle | any);

            g_if = 1'b0;
            g_dm = 1'b0;
            if (idle && any) begin
                if (if_req_in && dm_req_in) begin
`ifdef ARB_RR_EN
                    g_dm       = !rr_last_dm;
                    rr_last_dm = g_dm;
`else
                    g_dm = 1'b1;
`endif
                end else begin
                    g_dm = dm_req_in;
                end
                g_if = !g_dm;
            end
            chk1("if_gnt", if_gnt_out, g_if);
            chk1("dm_gnt", dm_gnt_out, g_dm);
            chk1("mem_en", mem_en_out, g_if | g_dm);
            if (g_dm) begin
                chk1("mem_we_dm", mem_we_out, dm_we_in);
                chk32("mem_addr_dm", mem_addr_out, dm_addr_in);
                chk32("mem_wdata_dm", mem_wdata_out, dm_wdata_in);
            end else if (g_if) begin
                chk1("mem_we_if", mem_we_out, 1'b0);
                chk32("mem_addr_if", mem_addr_out, if_addr_in);
            end else begin
                chk1("mem_we_idle", mem_we_out, 1'b0);
                chk32("mem_addr_idle", mem_addr_out, 32'h0);
                chk32("mem_wdata_idle", mem_wdata_out, 32'h0);
            end
            if (g_if || g_dm) begin
                pend     = 1'b1;
                pend_dm  = g_dm;
                pend_cyc = cyc;
            end

            // memory side reacts to whatever the DUT actually issues
            if (mem_en_out === 1'b1) begin
                if (mem_we_out === 1'b1) begin
                    mem_arr[mem_addr_out] = mem_wdata_out;
                end else begin
                    resp_due  = 1'b1;
                    resp_cyc  = cyc + MEM_LAT;
                    resp_data = mem_arr.exists(mem_addr_out) ? mem_arr[mem_addr_out]
                                                             : mem_init(mem_addr_out);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic if_access(input logic [ADDR_W-1:0] addr, input bit push);
        int n;
        if (push) if_exp_q.push_back(mem_init(addr));
        if_req_in  = 1'b1;
        if_addr_in = addr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if_gnt_out !== 1'b1 && n < 100);
        chk1("if_gnt_timeout", if_gnt_out, 1'b1);
        @(posedge clk);
        #1;
        if_req_in = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
        int n;
        logic [DATA_W-1:0] d;
        if (we) begin
            ref_mem[addr] = wdata;
            dm_exp_q.push_back(dm_last_load);
        end else begin
            d = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
            dm_exp_q.push_back(d);
            dm_last_load = d;
        end
        dm_req_in   = 1'b1;
        dm_we_in    = we;
        dm_addr_in  = addr;
        dm_wdata_in = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dm_gnt_out !== 1'b1 && n < 100);
        chk1("dm_gnt_timeout", dm_gnt_out, 1'b1);
        @(posedge clk);
        #1;
        dm_req_in = 1'b0;
        dm_we_in  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_in    = 1'b0;
        if_req_in   = 1'b0;
        if_addr_in  = '0;
        dm_req_in   = 1'b0;
        dm_we_in    = 1'b0;
        dm_addr_in  = '0;
        dm_wdata_in = '0;

        idle_cycles(3);
        reset_in = 1'b1;
        idle_cycles(2);

        // reset in the middle of a fetch: no valid pulse may follow
        if_access(32'h100, 1'b0);
        reset_in = 1'b0;
        idle_cycles(2);
        reset_in = 1'b1;
        idle_cycles(4);

        // single fetch, store, load-back
        if_access(32'h40, 1'b1);
        idle_cycles(4);
        dm_access(1'b1, 32'h10, 32'hDEAD_BEEF);
        idle_cycles(4);
        dm_access(1'b0, 32'h10, 32'h0);
        idle_cycles(4);

        // simultaneous requests
        fork
            if_access(32'h1004, 1'b1);
            dm_access(1'b0, 32'h2000, 32'h0);
        join
        idle_cycles(5);

        // request raised and dropped while busy must never be granted
        if (MEM_LAT >= 2) begin
            fork
                if_access(32'h1008, 1'b1);
                begin
                    int n;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (if_gnt_out !== 1'b1 && n < 100);
                    @(posedge clk);
                    #1;
                    dm_req_in  = 1'b1;
                    dm_addr_in = 32'h2040;
                    @(posedge clk);
                    #1;
                    dm_req_in  = 1'b0;
                    dm_addr_in = '0;
                end
            join
            idle_cycles(5);
        end

        // randomized concurrent traffic
        fork
            repeat (40) begin
                idle_cycles($urandom_range(0, 3));
                if_access(32'h1000 + 32'(4 * $urandom_range(0, 63)), 1'b1);
            end
            repeat (40) begin
                idle_cycles($urandom_range(0, 3));
                dm_access(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 7)),
                          32'($urandom));
            end
        join
        idle_cycles(MEM_LAT + 6);

        chk32("if_q_drained", 32'(if_exp_q.size()), 32'h0);
        chk32("dm_q_drained", 32'(dm_exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
